// File: rtl/fma16_dot_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fma16_dot_seq_if
// Brief    : Request, operand-stream, fma16 and status bundle of fma16_dot_seq.
// Revision : 1.0  initial release
// ============================================================================
interface fma16_dot_seq_if #(
    parameter int LENW = 5
);
    logic            start;
    logic [LENW-1:0] len;
    logic [15:0]     acc_init;
    logic [1:0]      roundmode;
    logic            negp;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_x;
    logic [15:0]     in_y;
    logic [15:0]     fma_x;
    logic [15:0]     fma_y;
    logic [15:0]     fma_z;
    logic            fma_mul;
    logic            fma_add;
    logic            fma_negp;
    logic            fma_negz;
    logic [1:0]      fma_roundmode;
    logic [15:0]     fma_result;
    logic [3:0]      fma_flags;
    logic            busy;
    logic            done;
    logic [15:0]     result;
    logic [3:0]      flags;

    modport master (
        output start, len, acc_init, roundmode, negp, in_valid, in_x, in_y,
        output fma_result, fma_flags,
        input  in_ready, fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp,
        input  fma_negz, fma_roundmode, busy, done, result, flags
    );

    modport slave (
        input  start, len, acc_init, roundmode, negp, in_valid, in_x, in_y,
        input  fma_result, fma_flags,
        output in_ready, fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp,
        output fma_negz, fma_roundmode, busy, done, result, flags
    );
endinterface
`default_nettype wire

// File: rtl/fma16_dot_seq.sv
`default_nettype none
// ============================================================================
// Module   : fma16_dot_seq
// Brief    : Sequential fp16 dot-product requester driving an external fma16.
// Revision : 1.0  initial release
// ============================================================================
module fma16_dot_seq #(
    parameter int LENW    = 5,
    parameter int FMA_LAT = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fma16_dot_seq_if.slave    bus
);
    localparam int WW = $clog2(FMA_LAT + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAITIN = 2'd1;
    localparam logic [1:0] c_EXEC   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [WW-1:0]   c_LAT      = WW'(FMA_LAT);
    localparam logic [WW-1:0]   c_WONE     = WW'(1);
    localparam logic [LENW-1:0] c_CNT_ONE  = LENW'(1);
    localparam logic [LENW-1:0] c_CNT_ZERO = '0;

    logic [1:0]      state_q,  state_d;
    logic [15:0]     acc_q,    acc_d;
    logic [LENW-1:0] cnt_q,    cnt_d;
    logic [WW-1:0]   wcnt_q,   wcnt_d;
    logic [3:0]      facc_q,   facc_d;
    logic [15:0]     fx_q,     fx_d;
    logic [15:0]     fy_q,     fy_d;
    logic [15:0]     fz_q,     fz_d;
    logic            negp_q,   negp_d;
    logic [1:0]      rm_q,     rm_d;
    logic [15:0]     result_q, result_d;
    logic [3:0]      flags_q,  flags_d;
    logic            done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        facc_d   = facc_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        fz_d     = fz_q;
        negp_d   = negp_q;
        rm_d     = rm_q;
        result_d = result_q;
        flags_d  = flags_q;
        // done trails the DONE state by one cycle so it lines up with result
        done_d   = (state_q == c_DONE);

        case (state_q)
            c_IDLE: begin
                if (bus.start) begin
                    if (bus.len != c_CNT_ZERO) begin
                        acc_d   = bus.acc_init;
                        cnt_d   = bus.len;
                        facc_d  = 4'b0000;
                        rm_d    = bus.roundmode;
                        negp_d  = bus.negp;
                        state_d = c_WAITIN;
                    end else begin
                        result_d = bus.acc_init;
                        flags_d  = 4'b0000;
                        state_d  = c_DONE;
                    end
                end
            end
            c_WAITIN: begin
                if (bus.in_valid) begin
                    fx_d    = bus.in_x;
                    fy_d    = bus.in_y;
                    fz_d    = acc_q;
                    wcnt_d  = c_LAT;
                    state_d = c_EXEC;
                end
            end
            c_EXEC: begin
                wcnt_d = wcnt_q - c_WONE;
                if (wcnt_q == c_WONE) begin
                    acc_d  = bus.fma_result;
                    facc_d = facc_q | bus.fma_flags;
                    cnt_d  = cnt_q - c_CNT_ONE;
                    if (cnt_q == c_CNT_ONE) begin
                        result_d = bus.fma_result;
                        flags_d  = facc_q | bus.fma_flags;
                        state_d  = c_DONE;
                    end else begin
                        state_d  = c_WAITIN;
                    end
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_IDLE;
            acc_q    <= 16'h0000;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            facc_q   <= 4'b0000;
            fx_q     <= 16'h0000;
            fy_q     <= 16'h0000;
            fz_q     <= 16'h0000;
            negp_q   <= 1'b0;
            rm_q     <= 2'b00;
            result_q <= 16'h0000;
            flags_q  <= 4'b0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            facc_q   <= facc_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            fz_q     <= fz_d;
            negp_q   <= negp_d;
            rm_q     <= rm_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign bus.in_ready      = (state_q == c_WAITIN);
    assign bus.busy          = (state_q == c_WAITIN) || (state_q == c_EXEC);
    assign bus.fma_x         = fx_q;
    assign bus.fma_y         = fy_q;
    assign bus.fma_z         = fz_q;
    assign bus.fma_mul       = 1'b1;
    assign bus.fma_add       = 1'b1;
    assign bus.fma_negp      = negp_q;
    assign bus.fma_negz      = 1'b0;
    assign bus.fma_roundmode = rm_q;
    assign bus.done          = done_q;
    assign bus.result        = result_q;
    assign bus.flags         = flags_q;
endmodule
`default_nettype wire

// File: tb/tb_fma16_dot_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fma16_dot_seq
// Brief    : Directed self-checking bench for fma16_dot_seq with a table fma16.
// Revision : 1.0  initial release
// ============================================================================
module tb_fma16_dot_seq;
    localparam int LENW    = 5;
    localparam int FMA_LAT = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fma16_dot_seq_if #(.LENW(LENW)) bus ();

    fma16_dot_seq #(.LENW(LENW), .FMA_LAT(FMA_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Hand-evaluated fma16 results for exactly the operand tuples this bench issues
    function automatic logic [19:0] fma_model(input logic ng, input logic [15:0] x,
                                              input logic [15:0] y, input logic [15:0] z);
        case ({ng, x, y, z})
            49'h0_3C00_4000_0000: fma_model = {4'b0000, 16'h4000};
            49'h0_4200_3800_4000: fma_model = {4'b0000, 16'h4300};
            49'h0_3C00_3C00_4300: fma_model = {4'b0000, 16'h4480};
            49'h1_3C00_4000_4200: fma_model = {4'b0000, 16'h3C00};
            49'h0_7800_3C00_7800: fma_model = {4'b0101, 16'h7C00};
            49'h0_0000_3C00_7C00: fma_model = {4'b0000, 16'h7C00};
            default:              fma_model = {4'b1000, 16'h7E00};
        endcase
    endfunction

    always_comb begin
        {bus.fma_flags, bus.fma_result} = fma_model(bus.fma_negp, bus.fma_x, bus.fma_y, bus.fma_z);
    end

    int errors = 0;
    int checks = 0;

    logic [15:0] xs [8];
    logic [15:0] ys [8];
    logic [15:0] z_log [8];
    logic        negp_obs;
    logic [1:0]  rm_obs;
    int          gap_ready;
    int          gap_unstable;
    bit          ready_seen;

    task automatic run_op(input logic [LENW-1:0] n, input logic [15:0] a0, input logic [1:0] rm,
                          input logic ng, input int gap, output int cyc, output bit to);
        int idx;
        int gc;
        bit consumed;
        logic [15:0] px, py, pz;
        idx = 0; gc = 0; to = 0; cyc = 0;
        gap_ready = 0; gap_unstable = 0; ready_seen = 0;
        bus.start = 1'b1; bus.len = n; bus.acc_init = a0; bus.roundmode = rm; bus.negp = ng;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        px = bus.fma_x; py = bus.fma_y; pz = bus.fma_z;
        while (bus.done !== 1'b1) begin
            if (cyc > 400) begin
                to = 1;
                break;
            end
            bus.in_valid = (idx < int'(n)) && (gc == 0);
            bus.in_x = (idx < 8) ? xs[idx] : 16'h0000;
            bus.in_y = (idx < 8) ? ys[idx] : 16'h0000;
            if (bus.in_ready === 1'b1) ready_seen = 1;
            if (bus.busy === 1'b1 && bus.in_ready === 1'b0 && idx > 0 && idx <= 8) begin
                z_log[idx-1] = bus.fma_z;
                negp_obs = bus.fma_negp;
                rm_obs = bus.fma_roundmode;
            end
            if (!bus.in_valid && idx > 0 && idx < int'(n) && bus.in_ready === 1'b1) begin
                gap_ready++;
                if (bus.fma_x !== px || bus.fma_y !== py || bus.fma_z !== pz) gap_unstable++;
            end
            consumed = bus.in_valid && (bus.in_ready === 1'b1);
            px = bus.fma_x; py = bus.fma_y; pz = bus.fma_z;
            @(posedge clk); #1;
            cyc++;
            if (consumed) begin
                idx++;
                gc = gap;
            end else if (gc > 0) begin
                gc--;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status busy/done/in_ready=%b required 000", {bus.busy, bus.done, bus.in_ready});
        end
        checks++;
        if ({bus.result, bus.flags} !== 20'h0) begin
            errors++;
            $display("FAIL reset_result result=%h flags=%b required 0000/0000", bus.result, bus.flags);
        end
        checks++;
        if ({bus.fma_x, bus.fma_y, bus.fma_z, bus.fma_negp, bus.fma_roundmode} !== 51'h0) begin
            errors++;
            $display("FAIL reset_fma x=%h y=%h z=%h negp=%b rm=%b required all zero",
                     bus.fma_x, bus.fma_y, bus.fma_z, bus.fma_negp, bus.fma_roundmode);
        end
        checks++;
        if ({bus.fma_mul, bus.fma_add, bus.fma_negz} !== 3'b110) begin
            errors++;
            $display("FAIL reset_consts mul/add/negz=%b required 110", {bus.fma_mul, bus.fma_add, bus.fma_negz});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc;
        bit to;
        xs[0] = 16'h3C00; ys[0] = 16'h4000;
        xs[1] = 16'h4200; ys[1] = 16'h3800;
        run_op(5'd2, 16'h0000, 2'b00, 1'b0, 0, cyc, to);
        checks++;
        if (to || cyc != 2 * (FMA_LAT + 1) + 2) begin
            errors++;
            $display("FAIL basic_latency cycles=%0d timeout=%0d required %0d", cyc, to, 2 * (FMA_LAT + 1) + 2);
        end
        checks++;
        if (bus.result !== 16'h4300 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL basic_result result=%h flags=%b required 4300/0000", bus.result, bus.flags);
        end
        checks++;
        if (z_log[1] !== 16'h4000) begin
            errors++;
            $display("FAIL basic_fma_z second z=%h required 4000", z_log[1]);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 16'h4300) begin
            errors++;
            $display("FAIL basic_pulse done=%b result=%h required 0/4300", bus.done, bus.result);
        end
    endtask

    task automatic test_len0();
        int cyc;
        bit to;
        run_op(5'd0, 16'h3C00, 2'b00, 1'b0, 0, cyc, to);
        checks++;
        if (to || cyc != 2) begin
            errors++;
            $display("FAIL len0_latency cycles=%0d timeout=%0d required 2", cyc, to);
        end
        checks++;
        if (bus.result !== 16'h3C00 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL len0_result result=%h flags=%b required 3C00/0000", bus.result, bus.flags);
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL len0_ready in_ready seen=1 required never");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_negp();
        int cyc;
        bit to;
        xs[0] = 16'h3C00; ys[0] = 16'h4000;
        run_op(5'd1, 16'h4200, 2'b10, 1'b1, 0, cyc, to);
        checks++;
        if (to || negp_obs !== 1'b1 || z_log[0] !== 16'h4200 || rm_obs !== 2'b10) begin
            errors++;
            $display("FAIL negp_drive negp=%b z=%h rm=%b timeout=%0d required 1/4200/10/0",
                     negp_obs, z_log[0], rm_obs, to);
        end
        checks++;
        if (bus.result !== 16'h3C00 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL negp_result result=%h flags=%b required 3C00/0000", bus.result, bus.flags);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        int cyc0, cyc1;
        bit to0, to1;
        xs[0] = 16'h3C00; ys[0] = 16'h4000;
        xs[1] = 16'h4200; ys[1] = 16'h3800;
        xs[2] = 16'h3C00; ys[2] = 16'h3C00;
        run_op(5'd3, 16'h0000, 2'b00, 1'b0, 0, cyc0, to0);
        checks++;
        if (to0 || bus.result !== 16'h4480) begin
            errors++;
            $display("FAIL nogap_result result=%h timeout=%0d required 4480/0", bus.result, to0);
        end
        @(posedge clk); #1;
        run_op(5'd3, 16'h0000, 2'b00, 1'b0, 5, cyc1, to1);
        checks++;
        if (to1 || bus.result !== 16'h4480 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL gap_result result=%h flags=%b timeout=%0d required 4480/0000/0",
                     bus.result, bus.flags, to1);
        end
        checks++;
        if (gap_ready != 2 * (5 - FMA_LAT) || gap_unstable != 0) begin
            errors++;
            $display("FAIL gap_hold ready_cycles=%0d unstable=%0d required %0d/0",
                     gap_ready, gap_unstable, 2 * (5 - FMA_LAT));
        end
        checks++;
        if (cyc1 != 3 * (FMA_LAT + 1) + 2 + 2 * (5 - FMA_LAT)) begin
            errors++;
            $display("FAIL gap_latency cycles=%0d required %0d", cyc1, 3 * (FMA_LAT + 1) + 2 + 2 * (5 - FMA_LAT));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int cyc;
        bit to;
        xs[0] = 16'h7800; ys[0] = 16'h3C00;
        xs[1] = 16'h0000; ys[1] = 16'h3C00;
        run_op(5'd2, 16'h7800, 2'b00, 1'b0, 0, cyc, to);
        checks++;
        if (to || bus.result !== 16'h7C00 || bus.flags !== 4'b0101) begin
            errors++;
            $display("FAIL ovf_sticky result=%h flags=%b timeout=%0d required 7C00/0101/0",
                     bus.result, bus.flags, to);
        end
        checks++;
        if (z_log[1] !== 16'h7C00) begin
            errors++;
            $display("FAIL ovf_fma_z second z=%h required 7C00", z_log[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_midreset();
        int cyc;
        bit to;
        int k;
        bit saw_done;
        bus.start = 1'b1; bus.len = 5'd3; bus.acc_init = 16'h0000;
        bus.roundmode = 2'b00; bus.negp = 1'b0;
        bus.in_valid = 1'b1; bus.in_x = 16'h3C00; bus.in_y = 16'h4000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.in_x = 16'h4200; bus.in_y = 16'h3800;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.fma_x !== 16'h4200) begin
            errors++;
            $display("FAIL mid_exec2 in_ready=%b busy=%b fma_x=%h required 0/1/4200",
                     bus.in_ready, bus.busy, bus.fma_x);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.in_ready} !== 3'b000 || bus.result !== 16'h0000 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset busy/done/rdy=%b result=%h flags=%b required 000/0000/0000",
                     {bus.busy, bus.done, bus.in_ready}, bus.result, bus.flags);
        end
        saw_done = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL mid_nodone done or busy seen after reset required none");
        end
        xs[0] = 16'h3C00; ys[0] = 16'h4000;
        run_op(5'd1, 16'h0000, 2'b00, 1'b0, 0, cyc, to);
        checks++;
        if (to || cyc != (FMA_LAT + 1) + 2 || bus.result !== 16'h4000 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL mid_restart result=%h flags=%b cycles=%0d timeout=%0d required 4000/0000/%0d/0",
                     bus.result, bus.flags, cyc, to, (FMA_LAT + 1) + 2);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.acc_init = 16'h0000; bus.roundmode = 2'b00;
        bus.negp = 1'b0; bus.in_valid = 1'b0; bus.in_x = 16'h0000; bus.in_y = 16'h0000;
        test_reset();
        test_basic();
        test_len0();
        test_negp();
        test_gaps();
        test_overflow();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fma16_dot_seq.md
Name: fma16_dot_seq

Overview:
Sequential requester for the combinational fma16 unit. It computes a fp16 dot product, acc = acc_init + sum(±x[i]*y[i]), over a stream of operand pairs. For each pair it drives one fma16 operation with z set to the running accumulator, then captures the result back into the accumulator. Sticky flags and the final result are reported to the issuing pipeline stage.

Parameters:
LENW, 5, width of the element-count input (up to 2^LENW-1 elements)
FMA_LAT, 1, cycles from operand issue to fma result sample (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  begin new dot product (sampled in IDLE only)
len  input  LENW  element count, sampled with start
acc_init  input  16  initial accumulator (fp16), sampled with start
roundmode  input  2  rounding mode, latched at start
negp  input  1  negate each product, latched at start
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts pair this cycle
in_x  input  16  multiplicand (fp16)
in_y  input  16  multiplier (fp16)
fma_x  output  16  to fma16 x
fma_y  output  16  to fma16 y
fma_z  output  16  to fma16 z (running accumulator)
fma_mul  output  1  to fma16 mul, constant 1
fma_add  output  1  to fma16 add, constant 1
fma_negp  output  1  to fma16 negp
fma_negz  output  1  to fma16 negz, constant 0
fma_roundmode  output  2  to fma16 roundmode
fma_result  input  16  from fma16 result
fma_flags  input  4  from fma16 flags {NV,OF,UF,NX}
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result/flags valid
result  output  16  final accumulator
flags  output  4  bitwise OR of all fma_flags captured this operation

Behaviour:
- Reset: state IDLE. busy=0, done=0, in_ready=0, result=0, flags=0, fma_x/y/z=0, fma_negp=0, fma_roundmode=0, internal counters=0. Reset mid-operation abandons it; no done pulse.
- All outputs are registered except in_ready, busy and the constant fma_mul/fma_add/fma_negz, which decode directly from state.
- IDLE: in_ready=0, busy=0.
  - start && len!=0: acc<=acc_init, cnt<=len, flag accumulator<=0, latch roundmode and negp → WAITIN.
  - start && len==0: result<=acc_init, flags<=0 → DONE.
  - No start: result and flags hold their previous values.
- WAITIN: busy=1, in_ready=1.
  - in_valid: fma_x<=in_x, fma_y<=in_y, fma_z<=acc, wcnt<=FMA_LAT → EXEC.
  - No in_valid: stay; fma_* outputs hold.
- EXEC: busy=1, in_ready=0, wcnt decrements each cycle.
  - On the cycle wcnt==1: acc<=fma_result, flag accumulator |= fma_flags, cnt<=cnt-1.
  - Then cnt==1 (last element) → DONE with result<=fma_result and flags<=accum|fma_flags; otherwise → WAITIN.
- DONE: done=1 for exactly one cycle, busy=0 → IDLE. result/flags hold until the next start is accepted.
- start while busy or in DONE: ignored. in_valid outside WAITIN: ignored, no pair consumed.
- Throughput: one pair per FMA_LAT+1 cycles at best. Latency from start to done is len*(FMA_LAT+1)+2 cycles with in_valid held high.
- fma_z always carries the accumulator from before the current element. The accumulator is never rounded locally; fma16 rounds each step.
- No arithmetic on fp16 values inside this block. cnt is LENW bits and cannot wrap because len==0 is handled in IDLE.

Test Plan:
- len=2, acc_init=0x0000, rne, negp=0, pairs (0x3C00,0x4000),(0x4200,0x3800), in_valid always 1 → done after 2*(FMA_LAT+1)+2 cycles, result=0x4300 (3.5), flags=0000.
- len=0, acc_init=0x3C00, start=1 → done pulses 2 cycles after start, result=0x3C00, flags=0000, in_ready never 1.
- len=1, acc_init=0x4200, negp=1, pair (0x3C00,0x4000) → fma_negp=1, fma_z=0x4200, result=0x3C00 (3-2).
- len=2, acc_init=0x7800, pairs (0x7800,0x3C00),(0x0000,0x3C00), rne → first step overflows, result=0x7C00, flags OF|NX=0101 held sticky though second step is exact.
- len=3, in_valid low 5 cycles between pairs → in_ready=1 throughout gaps, fma_x/y/z stable, cnt unchanged, final result equal to gap-free run.
- reset asserted in EXEC of element 2 of 3 → next cycle IDLE, busy=0, result=0, flags=0, no done. A following start with len=1 completes normally.
